scan_chain_controller: RTL and testbench
========================================

// Module: scan_chain_controller
// PURPOSE
//  Sequences one scan-capable parallel-load shift register chain for test/debug access.
//  A host request optionally captures the chain's functional data, then shifts a new
//  WIDTH-bit pattern in while the old contents are shifted out. The unloaded word is
//  returned over a valid/ready response port.
//  Sits between the debug/test host logic and the chain's enable/scan_enable/scan_in/scan_out pins.
// PARAMETERS
//  WIDTH   8   chain length in bits; must be >= 2
//  CNT_W   $clog2(WIDTH)   shift counter width (localparam, derived; not overridable)
// PORTS
//  clk                input   1      single clock; all logic on posedge
//  rst                input   1      synchronous, active-high reset
//  req_valid          input   1      host request valid
//  req_ready          output  1      controller can accept a request (high only in IDLE)
//  req_pattern        input   WIDTH  pattern to load into the chain
//  req_capture        input   1      1: pulse chain parallel load before shifting
//  abort              input   1      synchronous abort of the in-flight operation
//  rsp_valid          output  1      unloaded word valid
//  rsp_ready          input   1      host accepts response
//  rsp_data           output  WIDTH  word shifted out of the chain
//  chain_enable       output  1      to chain enable (parallel load)
//  chain_scan_enable  output  1      to chain scan_enable (shift toward MSB)
//  chain_scan_in      output  1      to chain scan_in (enters at bit 0)
//  chain_scan_out     input   1      from chain scan_out (= chain MSB)
//  busy               output  1      high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. rsp_valid, rsp_data, chain_enable, chain_scan_enable, chain_scan_in
//    and busy are all 0. req_ready=1 once rst is low. Requests seen while rst=1 are ignored.
//  - States: IDLE -> CAPTURE (only if req_capture) -> SHIFT -> RESP -> IDLE.
//  - Accept: req_valid & req_ready on an edge. Latch req_pattern into tx_reg, clear rx_reg
//    and cnt. Go to CAPTURE if req_capture=1, otherwise to SHIFT.
//  - CAPTURE: exactly 1 cycle with chain_enable=1 and chain_scan_enable=0. Then SHIFT.
//  - SHIFT: exactly WIDTH cycles with chain_scan_enable=1 and chain_enable=0.
//    chain_scan_in = tx_reg[WIDTH-1] (MSB first). On each edge:
//    tx_reg <= tx_reg<<1, rx_reg <= {rx_reg[WIDTH-2:0], chain_scan_out}, cnt++.
//    On the edge with cnt==WIDTH-1, go to RESP.
//    Result: chain holds req_pattern and rx_reg holds the prior chain contents, bit-exact.
//  - chain_enable and chain_scan_enable are never both 1. All chain outputs are registered
//    or decoded from state only.
//  - RESP: rsp_valid=1 and rsp_data=rx_reg, both held stable until rsp_valid & rsp_ready.
//    Then IDLE. rsp_valid drops the next cycle. No chain strobes in RESP.
//  - Latency: rsp_valid rises WIDTH edges after the accept edge (WIDTH+1 with capture).
//  - Back-to-back: req_ready=(state==IDLE), so the next accept is the cycle after the
//    response handshake.
//  - abort (in CAPTURE/SHIFT/RESP): next state is IDLE. Chain strobes are 0 from the next
//    cycle. No rsp_valid is produced or a pending one is dropped. Partial chain contents
//    are not restored. abort in IDLE has no effect. rst has priority over abort.
//  - Mid-operation reset: as for reset; the chain is not driven further.
// STRUCTURE
//  - Package scan_ctrl_pkg: typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, RESP}
//    scan_ctrl_state_t.
//  - One sub-module: scan_serdes_pair (tx/rx WIDTH-bit shift registers with load/clear/shift).
//    FSM and counter stay in the top level.
// TESTING (WIDTH=8, bench models the chain as a load/scan shift register)
//  1. Chain=8'hA5, req_pattern=8'h3C, capture=0 -> 8 scan_enable cycles, scan_in bits
//     0,0,1,1,1,1,0,0; rsp_data=8'hA5 at accept+8; chain=8'h3C.
//  2. Chain data_in=8'h5A, capture=1, pattern=8'hFF -> 1 chain_enable cycle then 8 shifts;
//     rsp_data=8'h5A at accept+9; chain=8'hFF.
//  3. rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0,
//     no chain strobes.
//  4. req_valid held with 8'h01 then 8'h80 -> 2nd accept cycle after 1st rsp handshake;
//     2nd rsp_data=8'h01.
//  5. abort at 4th SHIFT cycle -> scan_enable 0 next cycle, busy 0, no rsp_valid,
//     req_ready=1.
//  6. rst pulsed 2 cycles during SHIFT -> all outputs 0 next cycle, req_ready=1 after
//     release; new request completes normally.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller.
package scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        RESP    = 2'd3
    } scan_ctrl_state_t;

endpackage

// File: rtl/scan_serdes_pair.sv
// Transmit/receive shift register pair: tx unloads MSB first, rx collects the chain's scan_out.
module scan_serdes_pair #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic             i_serial_in,
    output logic             o_serial_out,
    output logic [WIDTH-1:0] o_rx
);

    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;

    // Clear zeroes tx so scan_in idles low after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (i_clear) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (i_load) begin
            r_tx <= i_pattern;
            r_rx <= '0;
        end else if (i_shift) begin
            r_tx <= {r_tx[WIDTH-2:0], 1'b0};
            r_rx <= {r_rx[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_serial_out = r_tx[WIDTH-1];
    assign o_rx         = r_rx;

endmodule

// File: rtl/scan_chain_controller.sv
// Sequences capture/shift/response for one scan chain; all outputs are registered.
module scan_chain_controller
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_pattern,
    input  logic             req_capture,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             chain_enable,
    output logic             chain_scan_enable,
    output logic             chain_scan_in,
    input  logic             chain_scan_out,
    output logic             busy
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    scan_ctrl_state_t r_state;
    scan_ctrl_state_t w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_load;
    logic             w_clear;
    logic             w_shift;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_chain_enable;
    logic             r_chain_scan_enable;
    logic             r_rsp_valid;
    logic             w_tx_msb;
    logic [WIDTH-1:0] w_rx;

    // Next-state and datapath control.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_shift    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_load     = 1'b1;
                    w_cnt_next = '0;
                    w_next     = req_capture ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: w_next = SHIFT;
            SHIFT: begin
                w_shift    = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_next  = IDLE;
            w_shift = 1'b0;
            w_clear = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= IDLE;
            r_cnt               <= '0;
            r_req_ready         <= 1'b1;
            r_busy              <= 1'b0;
            r_chain_enable      <= 1'b0;
            r_chain_scan_enable <= 1'b0;
            r_rsp_valid         <= 1'b0;
        end else begin
            r_state             <= w_next;
            r_cnt               <= w_cnt_next;
            r_req_ready         <= (w_next == IDLE);
            r_busy              <= (w_next != IDLE);
            r_chain_enable      <= (w_next == CAPTURE);
            r_chain_scan_enable <= (w_next == SHIFT);
            r_rsp_valid         <= (w_next == RESP);
        end
    end

    scan_serdes_pair #(
        .WIDTH(WIDTH)
    ) u_serdes (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_pattern    (req_pattern),
        .i_serial_in  (chain_scan_out),
        .o_serial_out (w_tx_msb),
        .o_rx         (w_rx)
    );

    assign req_ready         = r_req_ready;
    assign busy              = r_busy;
    assign chain_enable      = r_chain_enable;
    assign chain_scan_enable = r_chain_scan_enable;
    assign chain_scan_in     = w_tx_msb;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = w_rx;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Self-checking bench: transaction-level reference model plus a load/scan chain model.
module tb_scan_chain_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_pattern = 8'h00;
    logic       req_capture = 1'b0;
    logic       abort = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       chain_enable;
    logic       chain_scan_enable;
    logic       chain_scan_in;
    logic       chain_scan_out;
    logic       busy;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Chain model: parallel load from chain_din, shift toward MSB, preset hook for setup.
    logic [7:0] chain_q = 8'h00;
    logic [7:0] chain_din = 8'h00;
    logic       preset_en = 1'b0;
    logic [7:0] preset_val = 8'h00;

    // Reference model state: in-flight transaction described by edges since accept.
    bit         m_busy = 1'b0;
    int         m_k = 0;
    int         m_cap = 0;
    logic [7:0] m_pat = 8'h00;
    logic [7:0] m_rx = 8'h00;

    logic [7:0] rsp_q[$];

    scan_chain_controller #(.WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_pattern       (req_pattern),
        .req_capture       (req_capture),
        .abort             (abort),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .chain_enable      (chain_enable),
        .chain_scan_enable (chain_scan_enable),
        .chain_scan_in     (chain_scan_in),
        .chain_scan_out    (chain_scan_out),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    assign chain_scan_out = chain_q[7];

    always @(posedge clk) begin
        if (preset_en)              chain_q <= preset_val;
        else if (chain_enable)      chain_q <= chain_din;
        else if (chain_scan_enable) chain_q <= {chain_q[6:0], chain_scan_in};
    end

    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
    end

    // Reference: capture takes 1 cycle, shifting 8, then the response waits for rsp_ready.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                m_k    = 1;
                m_cap  = int'(req_capture);
                m_pat  = req_pattern;
                m_rx   = req_capture ? chain_din : chain_q;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else if (m_k >= 9 + m_cap) begin
            if (rsp_ready) m_busy = 1'b0;
        end else begin
            m_k = m_k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Per-cycle compare against the reference model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit e_en, e_se, e_val;
            e_en  = m_busy && (m_cap == 1) && (m_k == 1);
            e_se  = m_busy && (m_k >= 1 + m_cap) && (m_k <= 8 + m_cap);
            e_val = m_busy && (m_k >= 9 + m_cap);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("chain_enable", 32'(chain_enable), 32'(e_en));
            chk("chain_scan_enable", 32'(chain_scan_enable), 32'(e_se));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_val));
            if (!rst) chk("req_ready", 32'(req_ready), 32'(!m_busy));
            if (e_se) chk("scan_in", 32'(chain_scan_in), 32'(m_pat[7 - (m_k - 1 - m_cap)]));
            if (e_val) chk("rsp_data", 32'(rsp_data), 32'(m_rx));
        end
    end

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        preset_en = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    // Ends #1 after the accept edge.
    task automatic start_req(input logic [7:0] pat, input logic cap);
        int n;
        @(negedge clk);
        req_pattern = pat;
        req_capture = cap;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_bound("accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_to_rsp(output int lat, output logic [7:0] sin, output int n_en, output int n_se);
        lat = 0; sin = 8'h00; n_en = 0; n_se = 0;
        while (!rsp_valid && lat < 40) begin
            if (chain_enable) n_en++;
            if (chain_scan_enable) begin
                n_se++;
                sin = {sin[6:0], chain_scan_in};
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) fail_bound("rsp_valid");
    endtask

    task automatic finish_rsp(input int hold);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n_en, n_se, e1, e2, base, i, abort_at;
        logic [7:0] sin;
        bit prev_busy;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_scan_in", 32'(chain_scan_in), 32'h0);
        chk("rst_strobes", 32'({chain_enable, chain_scan_enable}), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // 1: shift-only
        preset(8'hA5);
        start_req(8'h3C, 1'b0);
        run_to_rsp(lat, sin, n_en, n_se);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_scan_in_bits", 32'(sin), 32'h3C);
        chk("t1_n_shift", 32'(n_se), 32'd8);
        chk("t1_n_enable", 32'(n_en), 32'd0);
        chk("t1_rsp_data", 32'(rsp_data), 32'hA5);
        chk("t1_chain", 32'(chain_q), 32'h3C);
        finish_rsp(0);
        chk("t1_rsp_drop", 32'(rsp_valid), 32'h0);

        // 2: capture then shift
        chain_din = 8'h5A;
        start_req(8'hFF, 1'b1);
        run_to_rsp(lat, sin, n_en, n_se);
        chk("t2_latency", 32'(lat), 32'd9);
        chk("t2_n_enable", 32'(n_en), 32'd1);
        chk("t2_n_shift", 32'(n_se), 32'd8);
        chk("t2_rsp_data", 32'(rsp_data), 32'h5A);
        chk("t2_chain", 32'(chain_q), 32'hFF);
        finish_rsp(0);

        // 3: response backpressure
        chain_din = 8'h69;
        start_req(8'h12, 1'b1);
        run_to_rsp(lat, sin, n_en, n_se);
        for (int k = 0; k < 5; k++) begin
            chk("t3_valid_held", 32'(rsp_valid), 32'h1);
            chk("t3_data_held", 32'(rsp_data), 32'h69);
            chk("t3_req_ready", 32'(req_ready), 32'h0);
            chk("t3_strobes", 32'({chain_enable, chain_scan_enable}), 32'h0);
            @(posedge clk);
            #1;
        end
        finish_rsp(0);

        // 4: back-to-back requests with req_valid held
        base = rsp_q.size();
        @(negedge clk);
        rsp_ready   = 1'b1;
        req_capture = 1'b0;
        req_pattern = 8'h01;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_pattern = 8'h80;
        e1 = -1; e2 = -1; i = 0;
        prev_busy = busy;
        while (rsp_q.size() < base + 2 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
            if (prev_busy && !busy && e1 < 0) e1 = i;
            if (!prev_busy && busy && e1 >= 0 && e2 < 0) begin
                e2 = i;
                req_valid = 1'b0;
            end
            prev_busy = busy;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        if (rsp_q.size() < base + 2) begin
            fail_bound("t4_responses");
        end else begin
            chk("t4_accept_gap", 32'(e2 - e1), 32'd1);
            chk("t4_rsp1", 32'(rsp_q[base]), 32'h12);
            chk("t4_rsp2", 32'(rsp_q[base + 1]), 32'h01);
        end
        @(posedge clk);
        #1;

        // 5: abort in the 4th shift cycle
        start_req(8'hE7, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("t5_shifting", 32'(chain_scan_enable), 32'h1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t5_scan_enable", 32'(chain_scan_enable), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("t5_no_rsp", 32'(rsp_valid), 32'h0);

        // 6: reset mid-shift
        start_req(8'h5F, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_outputs", 32'({busy, chain_enable, chain_scan_enable, chain_scan_in, rsp_valid}), 32'h0);
        chk("t6_rsp_data", 32'(rsp_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_req_ready", 32'(req_ready), 32'h1);
        chain_din = 8'hC3;
        start_req(8'h96, 1'b1);
        run_to_rsp(lat, sin, n_en, n_se);
        chk("t6_latency", 32'(lat), 32'd9);
        chk("t6_rsp_data_after", 32'(rsp_data), 32'hC3);
        chk("t6_chain", 32'(chain_q), 32'h96);
        finish_rsp(1);

        // Randomized transactions with occasional aborts and backpressure
        for (int t = 0; t < 40; t++) begin
            logic [7:0] pat;
            logic cap;
            pat = 8'($urandom);
            cap = 1'($urandom);
            if (!cap && ($urandom % 3 == 0)) preset(8'($urandom));
            chain_din = 8'($urandom);
            abort_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 8)) : -1;
            start_req(pat, cap);
            lat = 0;
            while (!rsp_valid && busy && lat < 40) begin
                if (lat == abort_at) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    break;
                end
                @(posedge clk);
                #1;
                lat++;
            end
            if (rsp_valid) finish_rsp(int'($urandom_range(0, 3)));
            else if (busy) fail_bound("rand_rsp");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
